// File: rtl/add_share_arb.sv
// Round-robin arbiter that time-shares one external combinational adder
// between two valid/ready requesters and routes each result back to its owner.
module add_share_arb #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_co,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_y,
  input  logic             add_co,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last_grant;
  logic             r_owner;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_co;
  logic [CNT_W-1:0] r_ops_done;
  logic             w_grant;
  logic             w_accept;
  logic             w_rsp_taken;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_accept    = (r_state == IDLE) && (req0_valid || req1_valid);
  assign w_rsp_taken = (r_state == RESP) && (r_owner ? rsp1_ready : rsp0_ready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = ADD;
      ADD:     w_next_state = RESP;
      RESP:    if (w_rsp_taken) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = 1'b0;
    case (r_state)
      IDLE: begin
        // NOTE: readies are combinational from valid, so they are masked by
        // rst_n to stay low for the whole time reset is asserted.
        req0_ready = rst_n & req0_valid & ~w_grant;
        req1_ready = rst_n & req1_valid &  w_grant;
      end
      ADD: busy = 1'b1;
      RESP: begin
        busy       = 1'b1;
        rsp0_valid = ~r_owner;
        rsp1_valid =  r_owner;
      end
      default: busy = 1'b0;
    endcase
  end

  // Datapath: operand capture, result capture, grant history, op counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_rsp_sum    <= '0;
      r_rsp_co     <= 1'b0;
      r_ops_done   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (w_accept) begin
        r_add_a <= w_grant ? req1_a : req0_a;
        r_add_b <= w_grant ? req1_b : req0_b;
        r_owner <= w_grant;
      end
      if (r_state == ADD) begin
        r_rsp_sum <= add_y;
        r_rsp_co  <= add_co;
      end
      if (w_rsp_taken) begin
        r_last_grant <= r_owner;
        r_ops_done   <= r_ops_done + CNT_W'(1);
      end
    end
  end

  assign add_a    = r_add_a;
  assign add_b    = r_add_b;
  assign rsp_sum  = r_rsp_sum;
  assign rsp_co   = r_rsp_co;
  assign ops_done = r_ops_done;

endmodule

// File: tb/tb_add_share_arb.sv
// Self-checking bench for add_share_arb: directed and random operations checked
// against a transaction-level model of grant order, sums and completion count.
module tb_add_share_arb;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;

  logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_co, add_co, busy;
  logic [W-1:0] rsp_sum, add_a, add_b, add_y;
  logic [7:0]   ops_done;

  logic         req0_ready2, req1_ready2, rsp0_valid2, rsp1_valid2, rsp_co2, add_co2, busy2;
  logic [W-1:0] rsp_sum2, add_a2, add_b2, add_y2;
  logic [1:0]   ops_done2;

  int checks = 0;
  int errors = 0;
  bit m_last;
  int m_ops;

  always #5 clk = ~clk;

  // External shared adder slices
  assign {add_co, add_y}   = {1'b0, add_a}  + {1'b0, add_b};
  assign {add_co2, add_y2} = {1'b0, add_a2} + {1'b0, add_b2};

  add_share_arb #(.WIDTH(W), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_sum(rsp_sum), .rsp_co(rsp_co),
    .add_a(add_a), .add_b(add_b), .add_y(add_y), .add_co(add_co),
    .busy(busy), .ops_done(ops_done)
  );

  // Narrow-counter instance driven identically, used for the wrap sequence
  add_share_arb #(.WIDTH(W), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready2), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready2), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid2), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid2), .rsp1_ready(rsp1_ready),
    .rsp_sum(rsp_sum2), .rsp_co(rsp_co2),
    .add_a(add_a2), .add_b(add_b2), .add_y(add_y2), .add_co(add_co2),
    .busy(busy2), .ops_done(ops_done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_req_ready", {req0_ready, req1_ready}, 0);
    check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    check("rst_busy", busy, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_co", rsp_co, 0);
    check("rst_ops_done", ops_done, 0);
    check("rst_ops_done2", ops_done2, 0);
  endtask

  // One complete operation, starting at a falling edge with the DUT idle.
  // Requests stay valid throughout; the owner's response ready is withheld
  // for 'hold' cycles while the other response ready is held high.
  task automatic do_op(input bit v0, input bit v1,
                       input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input int hold);
    bit           g;
    logic [W-1:0] a, b;
    logic [W:0]   s;
    g = (v0 && v1) ? !m_last : v1;
    a = g ? a1 : a0;
    b = g ? b1 : b0;
    s = {1'b0, a} + {1'b0, b};
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp0_ready = g ? 1'b1 : (hold == 0);
    rsp1_ready = g ? (hold == 0) : 1'b1;
    #1;
    check("idle_busy", busy, 0);
    check("grant_req0_ready", req0_ready, !g);
    check("grant_req1_ready", req1_ready, g);
    @(negedge clk);
    check("add_busy", busy, 1);
    check("add_a", add_a, a);
    check("add_b", add_b, b);
    check("add_req_ready", {req0_ready, req1_ready}, 0);
    check("add_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    @(negedge clk);
    for (int i = 0; i <= hold; i++) begin
      check("resp_rsp0_valid", rsp0_valid, !g);
      check("resp_rsp1_valid", rsp1_valid, g);
      check("resp_sum", rsp_sum, s[W-1:0]);
      check("resp_co", rsp_co, s[W]);
      check("resp_req_ready", {req0_ready, req1_ready}, 0);
      if (i == 0) check("resp_sum2", rsp_sum2, s[W-1:0]);
      if (i == hold) begin
        if (g) rsp1_ready = 1'b1;
        else   rsp0_ready = 1'b1;
      end
      @(negedge clk);
    end
    m_last = g;
    m_ops++;
    check("done_busy", busy, 0);
    check("ops_done", ops_done, m_ops % 256);
    check("ops_done_wrap", ops_done2, m_ops % 4);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    m_last = 1'b1;
    m_ops = 0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // No requests: stay idle
    #1;
    check("noreq_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    check("noreq_busy", busy, 0);
    check("noreq_ops", ops_done, 0);

    // Single requester
    do_op(1, 0, 5'd4, 5'd8,  5'd0, 5'd0, 0);
    do_op(1, 0, 5'd5, 5'd15, 5'd0, 5'd0, 0);
    do_op(1, 0, 5'd6, 5'd11, 5'd0, 5'd0, 0);

    // Carry-out on requester 1
    do_op(0, 1, 5'd0, 5'd0, 5'd20, 5'd15, 0);
    do_op(0, 1, 5'd0, 5'd0, 5'd31, 5'd31, 0);

    // Both continuously valid: alternating grants
    for (int i = 0; i < 4; i++) begin
      do_op(1, 1, W'(i + 1), W'(2 * i), W'(i + 10), W'(3 * i + 7), 0);
    end

    // Response backpressure with the other requester waiting
    do_op(1, 1, 5'd9, 5'd3, 5'd17, 5'd2, 10);
    do_op(0, 1, 5'd0, 5'd0, 5'd17, 5'd2, 0);

    // Randomized traffic
    for (int i = 0; i < 20; i++) begin
      bit rv0, rv1;
      rv0 = 1'($urandom());
      rv1 = 1'($urandom());
      if (!rv0 && !rv1) rv0 = 1'b1;
      do_op(rv0, rv1, W'($urandom()), W'($urandom()), W'($urandom()), W'($urandom()),
            int'($urandom_range(0, 3)));
    end

    // Reset while a response is pending
    req0_valid = 1'b1; req0_a = 5'd7; req0_b = 5'd9;
    req1_valid = 1'b1; req1_a = 5'd1; req1_b = 5'd2;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_resp", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    m_last = 1'b1;
    m_ops = 0;
    do_op(1, 1, 5'd3, 5'd4, 5'd10, 5'd11, 0);
    do_op(1, 1, 5'd3, 5'd4, 5'd10, 5'd11, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_share_arb.md
# add_share_arb

Round-robin controller that time-shares one external WIDTH-bit combinational adder between two requesters. Each requester submits an operand pair over a valid/ready handshake. The block drives the adder's operand inputs and samples its sum and carry-out. It returns the result to the owning requester over a second valid/ready handshake. It sits between client logic and the shared adder slice and is the only driver of that slice's inputs.

## Interface
- WIDTH, 5, operand, sum and adder port width
- CNT_W, 8, width of completed-operation counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands (unsigned)
- req1_valid, req1_ready, req1_a, req1_b  -  -  same for requester 1
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 takes result
- rsp1_valid, rsp1_ready  -  1  same for requester 1
- rsp_sum  out  WIDTH  result sum, shared by both response channels
- rsp_co  out  1  result carry-out, shared by both response channels
- add_a, add_b  out  WIDTH  operands to the shared adder (registered)
- add_y  in  WIDTH  adder sum, combinational from add_a/add_b
- add_co  in  1  adder carry-out
- busy  out  1  state is not IDLE
- ops_done  out  CNT_W  completed responses, wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, ADD, RESP. One operation is in flight at a time.
- IDLE:
  - If neither valid is high, remain in IDLE.
  - Otherwise grant one requester:
    - If only one valid is high, grant it.
    - If both are high, grant the requester not equal to last_grant.
  - reqN_ready is combinational: high only in IDLE, only for the granted N, only while reqN_valid is high. The non-granted ready is 0.
  - On handshake, register reqN_a/b into add_a/add_b, store the grant id, and go to ADD.
- ADD: capture add_y into rsp_sum and add_co into rsp_co, then go to RESP. One cycle; the adder settles within one clock.
- RESP:
  - Hold rspN_valid high for the stored id; the other rsp valid is 0.
  - Hold rsp_sum and rsp_co stable.
  - When rspN_ready is high:
    - go to IDLE;
    - set last_grant to the stored id;
    - increment ops_done, wrapping.
  - rsp_ready on the non-owning channel is ignored.
- Arithmetic: {rsp_co, rsp_sum} = a + b, unsigned, WIDTH+1 bits. The block passes through whatever the adder returns; it does no arithmetic itself.
- add_a/add_b hold their last value in IDLE. They are not cleared after use.
- A requester deasserting valid before ready is allowed; nothing is accepted.

## Timing
- Reset, asynchronous, while rst_n=0:
  - state IDLE, last_grant=1, so requester 0 wins the first tie;
  - add_a=add_b=0, rsp_sum=0, rsp_co=0, ops_done=0;
  - all ready/valid outputs 0, busy=0.
- Latency:
  - handshake at edge E0;
  - ADD during cycle E0..E1, with add_a/add_b valid from E0;
  - rspN_valid high from E1;
  - the earliest next accept is the cycle after the rsp handshake.
- Minimum 3 cycles per operation with rsp_ready held high, i.e. throughput 1/3.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…
- Reset mid-operation (ADD or RESP):
  - the operation is abandoned and no response is issued;
  - ops_done is not incremented;
  - last_grant returns to 1.
- rsp backpressure: RESP may persist indefinitely; new requests are not accepted, and their ready stays 0.
- ops_done wraps from 2^CNT_W−1 to 0.

## Test plan
- Reset values: assert rst_n=0 mid-RESP → next sampled cycle all outputs at reset values, state IDLE; after release, a tie grants requester 0.
- Single requester: req0 sends (4,8), then (5,15), then (6,11), rsp_ready=1 → rsp0 returns 12/co0, 20/co0, 17/co0, each rsp0_valid 2 cycles after its accept; rsp1_valid never high; ops_done=3.
- Carry-out: req1 sends (20,15) → rsp_sum=3, rsp_co=1 on rsp1. Then req1 sends (31,31) → rsp_sum=30, rsp_co=1.
- Arbitration: both valid continuously with distinct operands → grant order 0,1,0,1; ready never high on both in one cycle; each response routed to the correct channel.
- Backpressure: rsp0_ready=0 for 10 cycles with req1_valid=1 → rsp0_valid and rsp_sum stable; req1_ready stays 0; req1 is accepted the cycle after rsp0_ready rises.
- Counter wrap: with CNT_W=2, complete 5 operations → ops_done sequence 1,2,3,0,1.
